i2c_slave_ctl: RTL

I2C target (slave) bit/byte engine, the responder counterpart of the master bit controller. It synchronises and filters SCL/SDA and detects START and STOP. It matches a 7-bit address, ACKs writes and delivers received bytes, and serialises read bytes from the host side, stretching SCL while no read data is available. It sits between the open-drain pad wrapper and a register-file or FIFO front end.

---
 rtl/i2c_slave_ctl_if.sv | 31 +++
 rtl/i2c_slave_ctl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctl_if.sv
// i2c_slave_ctl_if: pad, host-side and status signals of the I2C target engine
interface i2c_slave_ctl_if;
    logic       i_enable;
    logic [6:0] i_slave_addr;
    logic       i_scl;
    logic       o_scl_oen;
    logic       i_sda;
    logic       o_sda_oen;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ack;
    logic       o_busy;
    logic       o_rw;
    logic       o_start_det;
    logic       o_stop_det;
    logic       o_master_nack;

    modport slave (
        input  i_enable, i_slave_addr, i_scl, i_sda, i_tx_data, i_tx_valid,
        output o_scl_oen, o_sda_oen, o_rx_data, o_rx_valid, o_tx_ack,
               o_busy, o_rw, o_start_det, o_stop_det, o_master_nack
    );

    modport master (
        output i_enable, i_slave_addr, i_scl, i_sda, i_tx_data, i_tx_valid,
        input  o_scl_oen, o_sda_oen, o_rx_data, o_rx_valid, o_tx_ack,
               o_busy, o_rw, o_start_det, o_stop_det, o_master_nack
    );
endinterface

// File: rtl/i2c_slave_ctl.sv
// i2c_slave_ctl: I2C target bit/byte engine with input filtering, address match and SCL stretching
module i2c_slave_ctl #(
    parameter int FILTER_LEN = 3,
    parameter int SDA_HOLD   = 4
) (
    input logic             i_sysclk,
    input logic             i_reset,
    i2c_slave_ctl_if.slave  bus
);
    localparam int HW = $clog2(SDA_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_LOAD, S_RD_DATA, S_RD_ACK
    } state_t;

    state_t        state;
    logic [1:0]    pin_s1, pin_s2, filt, filt_p;
    logic [1:0][2:0] flt_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [HW-1:0] hold_cnt;
    logic          scl, sda, scl_rise, scl_fall, start, stop, hold_evt;

    assign scl      = filt[0];
    assign sda      = filt[1];
    assign scl_rise = scl & ~filt_p[0];
    assign scl_fall = ~scl & filt_p[0];
    assign start    = ~sda & filt_p[1] & scl;
    assign stop     = sda & ~filt_p[1] & scl;
    assign hold_evt = hold_cnt == HW'(1);

    // Synchronise SCL/SDA and only accept a new level after FILTER_LEN agreeing samples
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            pin_s1  <= '1;
            pin_s2  <= '1;
            filt    <= '1;
            filt_p  <= '1;
            flt_cnt <= '0;
        end else if (!bus.i_enable) begin
            pin_s1  <= '1;
            pin_s2  <= '1;
            filt    <= '1;
            filt_p  <= '1;
            flt_cnt <= '0;
        end else begin
            pin_s1 <= {bus.i_sda, bus.i_scl};
            pin_s2 <= pin_s1;
            filt_p <= filt;
            for (int i = 0; i < 2; i++) begin
                if (pin_s2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == 3'(FILTER_LEN - 1)) begin
                    filt[i]    <= pin_s2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 3'd1;
                end
            end
        end
    end

    // Protocol FSM; the hold timer restarts on every SCL fall and SDA moves when it hits 1.
    // SDA_HOLD >= 2 keeps the read-load cycle ahead of the MSB hold point.
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            state             <= S_IDLE;
            bit_cnt           <= '0;
            shreg             <= '0;
            hold_cnt          <= '0;
            bus.o_scl_oen     <= 1'b1;
            bus.o_sda_oen     <= 1'b1;
            bus.o_rx_data     <= '0;
            bus.o_rx_valid    <= 1'b0;
            bus.o_tx_ack      <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_rw          <= 1'b0;
            bus.o_start_det   <= 1'b0;
            bus.o_stop_det    <= 1'b0;
            bus.o_master_nack <= 1'b0;
        end else if (!bus.i_enable) begin
            state             <= S_IDLE;
            bit_cnt           <= '0;
            shreg             <= '0;
            hold_cnt          <= '0;
            bus.o_scl_oen     <= 1'b1;
            bus.o_sda_oen     <= 1'b1;
            bus.o_rx_data     <= '0;
            bus.o_rx_valid    <= 1'b0;
            bus.o_tx_ack      <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_rw          <= 1'b0;
            bus.o_start_det   <= 1'b0;
            bus.o_stop_det    <= 1'b0;
            bus.o_master_nack <= 1'b0;
        end else begin
            bus.o_rx_valid    <= 1'b0;
            bus.o_tx_ack      <= 1'b0;
            bus.o_start_det   <= 1'b0;
            bus.o_stop_det    <= 1'b0;
            bus.o_master_nack <= 1'b0;
            hold_cnt <= scl_fall ? HW'(SDA_HOLD) : hold_cnt - HW'(hold_cnt != '0);
            if (start) begin
                state           <= S_ADDR;
                bit_cnt         <= '0;
                bus.o_scl_oen   <= 1'b1;
                bus.o_sda_oen   <= 1'b1;
                bus.o_busy      <= 1'b0;
                bus.o_start_det <= 1'b1;
            end else if (stop) begin
                state          <= S_IDLE;
                bus.o_scl_oen  <= 1'b1;
                bus.o_sda_oen  <= 1'b1;
                bus.o_busy     <= 1'b0;
                bus.o_stop_det <= 1'b1;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bus.o_rw   <= sda;
                            bus.o_busy <= shreg[6:0] == bus.i_slave_addr;
                            state      <= shreg[6:0] == bus.i_slave_addr ? S_ADDR_ACK : S_IDLE;
                        end
                    end
                    S_ADDR_ACK, S_WR_ACK: if (hold_evt && bus.o_sda_oen) begin
                        bus.o_sda_oen <= 1'b0;
                    end else if (scl_fall && !bus.o_sda_oen) begin
                        bus.o_sda_oen <= 1'b1;
                        state <= (state == S_WR_ACK || !bus.o_rw) ? S_WR_DATA : S_RD_LOAD;
                    end
                    S_WR_DATA: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bus.o_rx_data  <= {shreg[6:0], sda};
                            bus.o_rx_valid <= 1'b1;
                            state          <= S_WR_ACK;
                        end
                    end
                    S_RD_LOAD: if (bus.i_tx_valid) begin
                        bus.o_tx_ack <= 1'b1;
                        state        <= S_RD_DATA;
                        shreg        <= bus.o_scl_oen ? bus.i_tx_data : {bus.i_tx_data[6:0], 1'b0};
                        if (!bus.o_scl_oen) begin
                            bus.o_sda_oen <= bus.i_tx_data[7];
                            hold_cnt      <= HW'(SDA_HOLD);
                        end
                    end else begin
                        bus.o_scl_oen <= 1'b0;
                    end
                    S_RD_DATA: if (hold_evt) begin
                        if (!bus.o_scl_oen) begin
                            bus.o_scl_oen <= 1'b1;
                        end else begin
                            bus.o_sda_oen <= shreg[7];
                            shreg         <= {shreg[6:0], 1'b0};
                        end
                    end else if (scl_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (scl_fall && bit_cnt == 3'd0) begin
                        bus.o_sda_oen <= 1'b1;
                        state         <= S_RD_ACK;
                    end
                    S_RD_ACK: if (scl_rise && sda) begin
                        bus.o_master_nack <= 1'b1;
                        bus.o_sda_oen     <= 1'b1;
                        bus.o_busy        <= 1'b0;
                        state             <= S_IDLE;
                    end else if (scl_fall) begin
                        state <= S_RD_LOAD;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
